// File: rtl/spi_tx_multi.sv
`timescale 1ns/1ps
// SPI transmitter behind AHB-lite registers. A TX FIFO feeds a shifter with runtime CPOL/CPHA/bit order/divider.
// Zero-wait AHB (HREADY_RESP=1); pushes to a full FIFO are dropped and flagged in sticky OVF; frames run back to back.
module spi_tx_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_SS     = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  HSEL,
  input  logic                  HTRANS,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  output logic                  HREADY_RESP,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  SCLK,
  output logic [NUM_SS-1:0]     SS,
  output logic                  MOSI
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [6:0] LAST_HALF  = 7'(2 * DATA_WIDTH - 1);
  localparam logic [6:0] LAST_TRAIL = 7'(2 * DATA_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t                r_state;
  logic                  r_dp_wr, r_dp_rd;
  logic [1:0]            r_dp_addr;
  logic [18:0]           r_ctrl;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [LW-1:0]         r_level;
  logic [7:0]            r_cnt, r_div;
  logic [6:0]            r_half;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_cpol, r_cpha, r_lsb;
  logic                  r_sclk, r_mosi;
  logic [NUM_SS-1:0]     r_ss;

  logic                  w_ap, w_push_req, w_push, w_pop, w_full, w_empty, w_busy;
  logic                  w_ld_lsb, w_ld_cpha, w_first, w_out;
  logic [DATA_WIDTH-1:0] w_head, w_head_sh, w_shifted;
  logic [31:0]           w_status;
  logic                  w_unused;

  function automatic logic [NUM_SS-1:0] f_ss(input logic [2:0] sel);
    logic [NUM_SS-1:0] v;
    for (int i = 0; i < NUM_SS; i++) v[i] = (sel != 3'(i));
    return v;
  endfunction

  assign w_ap       = HSEL & HTRANS & HREADY;
  assign w_push_req = r_dp_wr && (r_dp_addr == 2'd2);
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_push     = w_push_req && !w_full;
  assign w_busy     = (r_state != S_IDLE);
  assign w_pop      = !w_empty && r_ctrl[0] &&
                      ((r_state == S_IDLE) || ((r_state == S_HOLD) && (r_cnt == r_div)));
  assign w_status   = {16'h0, 8'(r_level), 4'h0, r_ovf, w_busy, w_full, w_empty};
  assign w_unused   = &{1'b0, HADDR, HWDATA};

  // Frame format comes from CTRL when leaving IDLE, from the latched copy when chaining out of HOLD.
  assign w_ld_lsb   = (r_state == S_IDLE) ? r_ctrl[3] : r_lsb;
  assign w_ld_cpha  = (r_state == S_IDLE) ? r_ctrl[2] : r_cpha;
  assign w_head     = r_mem[r_rptr];
  assign w_first    = w_ld_lsb ? w_head[0] : w_head[DATA_WIDTH-1];
  assign w_head_sh  = w_ld_lsb ? (w_head >> 1) : (w_head << 1);
  assign w_out      = r_lsb ? r_shift[0] : r_shift[DATA_WIDTH-1];
  assign w_shifted  = r_lsb ? (r_shift >> 1) : (r_shift << 1);

  assign HREADY_RESP = 1'b1;
  assign SCLK        = r_sclk;
  assign SS          = r_ss;
  assign MOSI        = r_mosi;

  always_comb begin
    HRDATA = '0;
    if (r_dp_rd) begin
      case (r_dp_addr)
        2'd0:    HRDATA = {13'h0, r_ctrl};
        2'd1:    HRDATA = w_status;
        default: HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dp_wr   <= 1'b0;
      r_dp_rd   <= 1'b0;
      r_dp_addr <= 2'd0;
      r_ctrl    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_dp_wr   <= w_ap & HWRITE;
      r_dp_rd   <= w_ap & ~HWRITE;
      r_dp_addr <= HADDR[3:2];
      if (r_dp_wr && (r_dp_addr == 2'd0)) r_ctrl <= HWDATA[18:0] & 19'h7_FF0F;
      if (w_push_req && w_full)                  r_ovf <= 1'b1;
      else if (r_dp_rd && (r_dp_addr == 2'd1))   r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= HWDATA[DATA_WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss    <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sclk <= r_ctrl[1];
          r_ss   <= '1;
          r_mosi <= 1'b0;
          if (w_pop) begin
            r_cpol  <= r_ctrl[1];
            r_cpha  <= r_ctrl[2];
            r_lsb   <= r_ctrl[3];
            r_div   <= r_ctrl[15:8];
            r_ss    <= f_ss(r_ctrl[18:16]);
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == r_div) begin
            r_cnt   <= '0;
            r_half  <= '0;
            r_sclk  <= ~r_cpol;
            r_state <= S_SHIFT;
            if (r_cpha) begin
              r_mosi  <= w_out;
              r_shift <= w_shifted;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == r_div) begin
            r_cnt <= '0;
            if (r_half == LAST_HALF) begin
              r_state <= S_HOLD;
            end else begin
              r_half <= r_half + 7'd1;
              r_sclk <= ~r_sclk;
              // Even half ends on a trailing edge, odd half on the next leading edge.
              if (r_half[0] ? r_cpha : (!r_cpha && (r_half != LAST_TRAIL))) begin
                r_mosi  <= w_out;
                r_shift <= w_shifted;
              end
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          r_sclk <= r_cpol;
          if (r_cnt == r_div) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_state <= S_SETUP;
            end else begin
              r_ss    <= '1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_pop) begin
        r_shift <= w_ld_cpha ? w_head : w_head_sh;
        if (!w_ld_cpha) r_mosi <= w_first;
      end
    end
  end
endmodule

// File: tb/tb_spi_tx_multi.sv
`timescale 1ns/1ps
// Bench for spi_tx_multi: pushed words go to an expected queue, a pin monitor rebuilds words from MOSI on SCLK rises.
module tb_spi_tx_multi;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        HSEL = 1'b0, HTRANS = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic        HREADY_RESP;
  logic [31:0] HRDATA;
  logic        SCLK, MOSI;
  logic [3:0]  SS;

  spi_tx_multi #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .NUM_SS(4), .ADDR_WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HREADY(HREADY), .HREADY_RESP(HREADY_RESP), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .SCLK(SCLK), .SS(SS), .MOSI(MOSI)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] q_exp[$], q_obs[$];
  int          q_span[$];
  logic [3:0]  q_ss[$];

  logic        mon_prev = 1'b0, mon_lsb = 1'b0;
  int          mon_cnt = 0, mon_cyc = 0, mon_first = 0;
  logic [31:0] mon_word = '0;
  logic [3:0]  mon_ss = 4'hF;

  always @(negedge CLK) begin
    mon_cyc++;
    if (!RST_N) begin
      mon_cnt  = 0;
      mon_prev = SCLK;
    end else begin
      if (!mon_prev && SCLK && SS != 4'hF) begin
        mon_word = mon_lsb ? {MOSI, mon_word[31:1]} : {mon_word[30:0], MOSI};
        if (mon_cnt == 0) begin
          mon_first = mon_cyc;
          mon_ss    = SS;
        end
        mon_cnt++;
        if (mon_cnt == 32) begin
          q_obs.push_back(mon_word);
          q_span.push_back(mon_cyc - mon_first);
          q_ss.push_back(mon_ss);
          mon_cnt = 0;
        end
      end
      mon_prev = SCLK;
    end
  end

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge CLK); #1;
    HSEL = 1'b1; HTRANS = 1'b1; HWRITE = 1'b1; HADDR = {28'h0, addr};
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = 1'b0; HWRITE = 1'b0; HWDATA = data;
    @(posedge CLK); #1;
  endtask

  task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
    @(posedge CLK); #1;
    HSEL = 1'b1; HTRANS = 1'b1; HWRITE = 1'b0; HADDR = {28'h0, addr};
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = 1'b0;
    data = HRDATA;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && q_obs.size() < n; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++; if (SCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b exp 0", SCLK); end
    n_tests++; if (SS !== 4'hF) begin n_fail++; $display("FAIL reset_ss got %h exp f", SS); end
    n_tests++; if (MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b exp 0", MOSI); end
    n_tests++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h exp 0", HRDATA); end
    n_tests++; if (HREADY_RESP !== 1'b1) begin n_fail++; $display("FAIL reset_hready got %b exp 1", HREADY_RESP); end
    RST_N = 1'b1;
    ahb_read(4'h4, d);
    n_tests++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got %h exp 00000001", d); end
  endtask

  task automatic test_mode0();
    logic [31:0] d, e, o;
    int sp;
    logic [3:0] s;
    mon_lsb = 1'b0;
    ahb_write(4'h0, 32'h0000_0001);
    q_exp.push_back(32'hA5A5_A5A5);
    ahb_write(4'h8, 32'hA5A5_A5A5);
    wait_obs(1, 400);
    n_tests++;
    if (q_obs.size() == 0) begin
      n_fail++; $display("FAIL mode0_frame got no word exp 1 word");
      q_exp.delete();
    end else begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); sp = q_span.pop_front(); s = q_ss.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL mode0_word got %h exp %h", o, e); end
      n_tests++; if (sp != 62) begin n_fail++; $display("FAIL mode0_span got %0d exp 62", sp); end
      n_tests++; if (s !== 4'hE) begin n_fail++; $display("FAIL mode0_ss got %h exp e", s); end
    end
    repeat (10) @(posedge CLK);
    #1;
    n_tests++; if (SS !== 4'hF) begin n_fail++; $display("FAIL mode0_ss_after got %h exp f", SS); end
    ahb_read(4'h4, d);
    n_tests++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL mode0_status got %h exp 00000001", d); end
  endtask

  task automatic test_mode3_lsb();
    logic [31:0] e, o;
    int sp;
    logic [3:0] s;
    mon_lsb = 1'b1;
    ahb_write(4'h0, 32'h0002_030F);
    repeat (2) @(posedge CLK);
    #1;
    n_tests++; if (SCLK !== 1'b1) begin n_fail++; $display("FAIL mode3_idle_sclk got %b exp 1", SCLK); end
    q_exp.push_back(32'h0000_0001);
    ahb_write(4'h8, 32'h0000_0001);
    wait_obs(1, 1000);
    n_tests++;
    if (q_obs.size() == 0) begin
      n_fail++; $display("FAIL mode3_frame got no word exp 1 word");
      q_exp.delete();
    end else begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); sp = q_span.pop_front(); s = q_ss.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL mode3_word got %h exp %h", o, e); end
      n_tests++; if (sp != 248) begin n_fail++; $display("FAIL mode3_span got %0d exp 248", sp); end
      n_tests++; if (s !== 4'hB) begin n_fail++; $display("FAIL mode3_ss got %h exp b", s); end
    end
    repeat (20) @(posedge CLK);
  endtask

  task automatic test_overflow();
    logic [31:0] d, e, o;
    int sp;
    logic [3:0] s;
    mon_lsb = 1'b0;
    ahb_write(4'h0, 32'h0000_0000);
    for (int i = 0; i < 9; i++) begin
      d = 32'hC0DE_0000 + 32'(i) * 32'h0101_1111;
      if (i < 8) q_exp.push_back(d);
      ahb_write(4'h8, d);
    end
    ahb_read(4'h4, d);
    n_tests++; if (d !== 32'h0000_080A) begin n_fail++; $display("FAIL ovf_status1 got %h exp 0000080a", d); end
    ahb_read(4'h4, d);
    n_tests++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL ovf_status2 got %h exp 00000802", d); end
    ahb_write(4'h0, 32'h0000_0001);
    wait_obs(8, 2000);
    n_tests++; if (q_obs.size() != 8) begin n_fail++; $display("FAIL ovf_drain_count got %0d exp 8", q_obs.size()); end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); sp = q_span.pop_front(); s = q_ss.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL ovf_drain_word got %h exp %h", o, e); end
    end
    q_exp.delete();
    repeat (200) @(posedge CLK);
    n_tests++; if (q_obs.size() != 0) begin n_fail++; $display("FAIL ovf_dropped_word got %0d extra exp 0", q_obs.size()); end
    q_obs.delete(); q_span.delete(); q_ss.delete();
    ahb_read(4'h4, d);
    n_tests++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_status_end got %h exp 00000001", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e, o;
    logic [31:0] l1, l2, l3;
    int sp, gaps, n;
    logic [3:0] s;
    logic ss_seen;
    mon_lsb = 1'b0;
    gaps = 0; n = 0; ss_seen = 1'b0;
    ahb_write(4'h0, 32'h0000_0000);
    q_exp.push_back(32'hDEAD_BEEF); ahb_write(4'h8, 32'hDEAD_BEEF);
    q_exp.push_back(32'h0123_4567); ahb_write(4'h8, 32'h0123_4567);
    q_exp.push_back(32'h8000_0001); ahb_write(4'h8, 32'h8000_0001);
    ahb_read(4'h4, d);
    n_tests++; if (d !== 32'h0000_0300) begin n_fail++; $display("FAIL b2b_level3 got %h exp 00000300", d); end
    fork
      begin
        while (SS[0] !== 1'b0 && n < 200) begin @(negedge CLK); n++; end
        ss_seen = (SS[0] === 1'b0);
        n = 0;
        while (q_obs.size() < 3 && n < 1000) begin
          @(negedge CLK);
          if (SS[0] !== 1'b0) gaps++;
          n++;
        end
      end
      begin
        ahb_write(4'h0, 32'h0000_0001);
        repeat (10) @(posedge CLK);
        ahb_read(4'h4, l1);
        wait_obs(1, 500);
        repeat (10) @(posedge CLK);
        ahb_read(4'h4, l2);
        wait_obs(2, 500);
        repeat (10) @(posedge CLK);
        ahb_read(4'h4, l3);
        wait_obs(3, 500);
      end
    join
    n_tests++; if (!ss_seen) begin n_fail++; $display("FAIL b2b_ss_low got %b exp 0", SS[0]); end
    n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_ss_gap got %0d high cycles exp 0", gaps); end
    n_tests++; if (l1 !== 32'h0000_0204) begin n_fail++; $display("FAIL b2b_level2 got %h exp 00000204", l1); end
    n_tests++; if (l2 !== 32'h0000_0104) begin n_fail++; $display("FAIL b2b_level1 got %h exp 00000104", l2); end
    n_tests++; if (l3 !== 32'h0000_0005) begin n_fail++; $display("FAIL b2b_level0 got %h exp 00000005", l3); end
    n_tests++; if (q_obs.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", q_obs.size()); end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); sp = q_span.pop_front(); s = q_ss.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_word got %h exp %h", o, e); end
      n_tests++; if (s !== 4'hE) begin n_fail++; $display("FAIL b2b_ss_sel got %h exp e", s); end
    end
    q_exp.delete(); q_obs.delete(); q_span.delete(); q_ss.delete();
    repeat (20) @(posedge CLK);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    mon_lsb = 1'b0;
    ahb_write(4'h0, 32'h0000_0001);
    ahb_write(4'h8, 32'h1234_5678);
    for (int i = 0; i < 500; i++) begin
      @(posedge CLK); #1;
      if (mon_cnt >= 10) break;
    end
    n_tests++; if (mon_cnt < 10) begin n_fail++; $display("FAIL midrst_reach_bit10 got %0d bits exp 10", mon_cnt); end
    RST_N = 1'b0;
    #1;
    n_tests++; if (SS !== 4'hF) begin n_fail++; $display("FAIL midrst_ss got %h exp f", SS); end
    n_tests++; if (SCLK !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk got %b exp 0", SCLK); end
    n_tests++; if (MOSI !== 1'b0) begin n_fail++; $display("FAIL midrst_mosi got %b exp 0", MOSI); end
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    ahb_read(4'h4, d);
    n_tests++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL midrst_status got %h exp 00000001", d); end
    repeat (100) @(posedge CLK);
    n_tests++; if (q_obs.size() != 0) begin n_fail++; $display("FAIL midrst_no_frame got %0d words exp 0", q_obs.size()); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
